// File: rtl/regfile_rename_ckpt_pkg.sv
// Shared constants for the rename-status register file.
// Defaults for widths, checkpoint depth and the null ROB tag.
package regfile_rename_ckpt_pkg;
  localparam int XLEN      = 32;
  localparam int DEF_RAW   = 5;
  localparam int DEF_TW    = 4;
  localparam int DEF_NCKPT = 4;
  localparam int TAG_NONE  = 0;
endpackage

// File: rtl/regfile_rename_ckpt_fifo.sv
// Checkpoint FIFO of busy/tag snapshots for branch recovery.
// Ports: commit-clear in, save data in, restore table out, tail/full out.
module regfile_rename_ckpt_fifo
  import regfile_rename_ckpt_pkg::*;
#(
  parameter int RAW      = DEF_RAW,
  parameter int TW       = DEF_TW,
  parameter int NC       = 1,
  parameter int NUM_CKPT = DEF_NCKPT,
  localparam int NREG    = 1 << RAW,
  localparam int CW      = $clog2(NUM_CKPT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic [NC-1:0]     cm_valid,
  input  logic [NC*RAW-1:0] cm_rd,
  input  logic [NC*TW-1:0]  cm_tag,
  input  logic              save,
  input  logic [NREG-1:0]   save_busy,
  input  logic [NREG*TW-1:0] save_tag,
  input  logic              rel,
  input  logic              restore,
  input  logic [CW-1:0]     restore_id,
  output logic [NREG-1:0]   restore_busy,
  output logic [NREG*TW-1:0] restore_tag,
  output logic [CW-1:0]     tail,
  output logic              full
);

  logic          slot_busy [NUM_CKPT][NREG];
  logic [TW-1:0] slot_tag  [NUM_CKPT][NREG];
  logic [CW-1:0] head;
  logic [CW:0]   count;
  logic          rel_ok;
  logic          save_ok;

  function automatic logic hit(
    input logic [RAW-1:0] r,
    input logic [TW-1:0]  t
  );
    hit = 1'b0;
    for (int c = 0; c < NC; c++)
      if (cm_valid[c] && r != '0 &&
          cm_rd[c*RAW +: RAW] == r &&
          cm_tag[c*TW +: TW] == t)
        hit = 1'b1;
  endfunction

  assign full = (count == (CW+1)'(NUM_CKPT));

  // Restored table already reflects this cycle's commits.
  for (genvar r = 0; r < NREG; r++) begin : g_rd
    logic h;
    assign h = hit(RAW'(r), slot_tag[restore_id][r]);
    assign restore_busy[r] = slot_busy[restore_id][r] & ~h;
    assign restore_tag[r*TW +: TW] =
      restore_busy[r] ? slot_tag[restore_id][r] : TW'(TAG_NONE);
  end

  always_comb begin
    rel_ok  = rel && (count != '0) && !flush &&
              (!restore || restore_id != head);
    save_ok = save && !flush && !restore && (!full || rel_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int k = 0; k < NUM_CKPT; k++)
        for (int r = 0; r < NREG; r++) begin
          slot_busy[k][r] <= 1'b0;
          slot_tag[k][r]  <= TW'(TAG_NONE);
        end
    end else if (rdy) begin
      for (int k = 0; k < NUM_CKPT; k++)
        for (int r = 0; r < NREG; r++)
          if (hit(RAW'(r), slot_tag[k][r])) begin
            slot_busy[k][r] <= 1'b0;
            slot_tag[k][r]  <= TW'(TAG_NONE);
          end
      if (save_ok)
        for (int r = 0; r < NREG; r++) begin
          slot_busy[tail][r] <= save_busy[r];
          slot_tag[tail][r]  <= save_tag[r*TW +: TW];
        end
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else if (restore) begin
        tail  <= restore_id;
        head  <= head + CW'(rel_ok);
        count <= {1'b0, CW'(restore_id - head - CW'(rel_ok))};
      end else begin
        head  <= head + CW'(rel_ok);
        tail  <= tail + CW'(save_ok);
        count <= count + (CW+1)'(save_ok) - (CW+1)'(rel_ok);
      end
    end
  end

endmodule

// File: rtl/regfile_rename_ckpt.sv
// Architectural register file with rename table, commit forwarding
// and checkpointed busy/tag state. Ports: operand read, rename, commit, ckpt.
module regfile_rename_ckpt
  import regfile_rename_ckpt_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_RAW,
  parameter int TAG_WIDTH      = DEF_TW,
  parameter int NUM_SRC        = 2,
  parameter int NUM_COMMIT     = 1,
  parameter int NUM_CKPT       = DEF_NCKPT,
  localparam int RAW  = REG_ADDR_WIDTH,
  localparam int TW   = TAG_WIDTH,
  localparam int NC   = NUM_COMMIT,
  localparam int NREG = 1 << RAW,
  localparam int CW   = $clog2(NUM_CKPT)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic [NUM_SRC*RAW-1:0] src_addr,
  output logic [NUM_SRC*XLEN-1:0] src_val,
  output logic [NUM_SRC-1:0]     src_busy,
  output logic [NUM_SRC*TW-1:0]  src_tag,
  input  logic                   ren_valid,
  input  logic [RAW-1:0]         ren_rd,
  input  logic [TW-1:0]          ren_tag,
  input  logic [NC-1:0]          cm_valid,
  input  logic [NC*RAW-1:0]      cm_rd,
  input  logic [NC*TW-1:0]       cm_tag,
  input  logic [NC*XLEN-1:0]     cm_val,
  input  logic                   ckpt_save,
  output logic [CW-1:0]          ckpt_id,
  output logic                   ckpt_full,
  input  logic                   ckpt_release,
  input  logic                   ckpt_restore,
  input  logic [CW-1:0]          ckpt_restore_id
);

  logic [XLEN-1:0] regs   [NREG];
  logic            busy   [NREG];
  logic [TW-1:0]   tag    [NREG];
  logic            busy_n [NREG];
  logic [TW-1:0]   tag_n  [NREG];

  logic [NREG-1:0]    nx_busy;
  logic [NREG*TW-1:0] nx_tag;
  logic [NREG-1:0]    rs_busy;
  logic [NREG*TW-1:0] rs_tag;

  function automatic logic hit(
    input logic [RAW-1:0] r,
    input logic [TW-1:0]  t
  );
    hit = 1'b0;
    for (int c = 0; c < NC; c++)
      if (cm_valid[c] && r != '0 &&
          cm_rd[c*RAW +: RAW] == r &&
          cm_tag[c*TW +: TW] == t)
        hit = 1'b1;
  endfunction

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [RAW-1:0]  a;
    logic [XLEN-1:0] v;
    logic            b;
    assign a = src_addr[s*RAW +: RAW];
    always_comb begin
      v = regs[a];
      for (int c = 0; c < NC; c++)
        if (cm_valid[c] && cm_rd[c*RAW +: RAW] == a)
          v = cm_val[c*XLEN +: XLEN];
      if (a == '0)
        v = '0;
    end
    assign b = busy[a] & ~hit(a, tag[a]) & (a != '0);
    assign src_val[s*XLEN +: XLEN] = v;
    assign src_busy[s] = b;
    assign src_tag[s*TW +: TW] = b ? tag[a] : TW'(TAG_NONE);
  end

  // Commit clears first, then rename overrides on the same register.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_n[r] = busy[r];
      tag_n[r]  = tag[r];
      if (hit(RAW'(r), tag[r])) begin
        busy_n[r] = 1'b0;
        tag_n[r]  = TW'(TAG_NONE);
      end
    end
    if (ren_valid && ren_rd != '0) begin
      busy_n[ren_rd] = 1'b1;
      tag_n[ren_rd]  = ren_tag;
    end
  end

  for (genvar r = 0; r < NREG; r++) begin : g_pk
    assign nx_busy[r] = busy_n[r];
    assign nx_tag[r*TW +: TW] = tag_n[r];
  end

  regfile_rename_ckpt_fifo #(
    .RAW      (RAW),
    .TW       (TW),
    .NC       (NC),
    .NUM_CKPT (NUM_CKPT)
  ) u_fifo (
    .clk          (clk_in),
    .rst          (rst_in),
    .rdy          (rdy_in),
    .flush        (flush_in),
    .cm_valid     (cm_valid),
    .cm_rd        (cm_rd),
    .cm_tag       (cm_tag),
    .save         (ckpt_save),
    .save_busy    (nx_busy),
    .save_tag     (nx_tag),
    .rel          (ckpt_release),
    .restore      (ckpt_restore),
    .restore_id   (ckpt_restore_id),
    .restore_busy (rs_busy),
    .restore_tag  (rs_tag),
    .tail         (ckpt_id),
    .full         (ckpt_full)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        busy[r] <= 1'b0;
        tag[r]  <= TW'(TAG_NONE);
      end
    end else if (rdy_in) begin
      for (int c = 0; c < NC; c++)
        if (cm_valid[c] && cm_rd[c*RAW +: RAW] != '0)
          regs[cm_rd[c*RAW +: RAW]] <= cm_val[c*XLEN +: XLEN];
      for (int r = 0; r < NREG; r++) begin
        if (flush_in) begin
          busy[r] <= 1'b0;
          tag[r]  <= TW'(TAG_NONE);
        end else if (ckpt_restore) begin
          busy[r] <= rs_busy[r];
          tag[r]  <= rs_tag[r*TW +: TW];
        end else begin
          busy[r] <= busy_n[r];
          tag[r]  <= tag_n[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_rename_ckpt.sv
// Directed self-checking bench for regfile_rename_ckpt.
// Linear stimulus with immediate assertions at each check point.
module tb_regfile_rename_ckpt;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic [9:0]  src_addr;
  logic [63:0] src_val;
  logic [1:0]  src_busy;
  logic [7:0]  src_tag;
  logic        ren_valid;
  logic [4:0]  ren_rd;
  logic [3:0]  ren_tag;
  logic [0:0]  cm_valid;
  logic [4:0]  cm_rd;
  logic [3:0]  cm_tag;
  logic [31:0] cm_val;
  logic        ckpt_save;
  logic [1:0]  ckpt_id;
  logic        ckpt_full;
  logic        ckpt_release;
  logic        ckpt_restore;
  logic [1:0]  ckpt_restore_id;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_rename_ckpt dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .flush_in        (flush_in),
    .src_addr        (src_addr),
    .src_val         (src_val),
    .src_busy        (src_busy),
    .src_tag         (src_tag),
    .ren_valid       (ren_valid),
    .ren_rd          (ren_rd),
    .ren_tag         (ren_tag),
    .cm_valid        (cm_valid),
    .cm_rd           (cm_rd),
    .cm_tag          (cm_tag),
    .cm_val          (cm_val),
    .ckpt_save       (ckpt_save),
    .ckpt_id         (ckpt_id),
    .ckpt_full       (ckpt_full),
    .ckpt_release    (ckpt_release),
    .ckpt_restore    (ckpt_restore),
    .ckpt_restore_id (ckpt_restore_id)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic idle();
    flush_in        = 1'b0;
    ren_valid       = 1'b0;
    ren_rd          = '0;
    ren_tag         = '0;
    cm_valid        = '0;
    cm_rd           = '0;
    cm_tag          = '0;
    cm_val          = '0;
    ckpt_save       = 1'b0;
    ckpt_release    = 1'b0;
    ckpt_restore    = 1'b0;
    ckpt_restore_id = '0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic ren(input logic [4:0] rd, input logic [3:0] t);
    ren_valid = 1'b1;
    ren_rd    = rd;
    ren_tag   = t;
  endtask

  task automatic cm(input logic [4:0] rd, input logic [3:0] t,
                    input logic [31:0] v);
    cm_valid = 1'b1;
    cm_rd    = rd;
    cm_tag   = t;
    cm_val   = v;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    src_addr = {a1, a0};
    #1;
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle();
    rd2(5'd5, 5'd3);
    chk("rst_val", src_val[31:0], 32'h0);
    chk("rst_busy", {30'd0, src_busy}, 32'h0);
    chk("rst_ckpt_id", {30'd0, ckpt_id}, 32'h0);
    chk("rst_full", {31'd0, ckpt_full}, 32'h0);
    tick();
    rst_in = 1'b0;

    // rename then forwarded commit
    ren(5'd5, 4'd3);
    rd2(5'd5, 5'd0);
    chk("ren_not_visible", {31'd0, src_busy[0]}, 32'h0);
    tick();
    idle();
    rd2(5'd5, 5'd0);
    chk("ren_busy", {31'd0, src_busy[0]}, 32'h1);
    chk("ren_tag", {28'd0, src_tag[3:0]}, 32'h3);
    cm(5'd5, 4'd3, 32'hDEAD);
    rd2(5'd5, 5'd0);
    chk("fwd_val", src_val[31:0], 32'hDEAD);
    chk("fwd_busy", {31'd0, src_busy[0]}, 32'h0);
    chk("fwd_tag", {28'd0, src_tag[3:0]}, 32'h0);
    tick();
    idle();
    rd2(5'd5, 5'd0);
    chk("cm_val_reg", src_val[31:0], 32'hDEAD);
    chk("cm_busy_clr", {31'd0, src_busy[0]}, 32'h0);

    // stale commit does not clear younger rename
    ren(5'd5, 4'd3);
    tick();
    ren(5'd5, 4'd7);
    tick();
    idle();
    cm(5'd5, 4'd3, 32'h1111);
    rd2(5'd5, 5'd0);
    chk("stale_fwd_val", src_val[31:0], 32'h1111);
    chk("stale_fwd_busy", {31'd0, src_busy[0]}, 32'h1);
    tick();
    idle();
    rd2(5'd5, 5'd0);
    chk("stale_busy", {31'd0, src_busy[0]}, 32'h1);
    chk("stale_tag", {28'd0, src_tag[3:0]}, 32'h7);
    chk("stale_reg", src_val[31:0], 32'h1111);
    cm(5'd5, 4'd7, 32'h2222);
    tick();
    idle();
    rd2(5'd5, 5'd0);
    chk("young_cm_busy", {31'd0, src_busy[0]}, 32'h0);

    // checkpoint restore with commit clear on the snapshot
    ren(5'd1, 4'd1);
    tick();
    idle();
    chk("pre_save_id", {30'd0, ckpt_id}, 32'h0);
    ckpt_save = 1'b1;
    tick();
    idle();
    chk("save_id", {30'd0, ckpt_id}, 32'h1);
    ren(5'd1, 4'd2);
    tick();
    idle();
    rd2(5'd1, 5'd0);
    chk("x1_tag2", {28'd0, src_tag[3:0]}, 32'h2);
    cm(5'd1, 4'd1, 32'hAB);
    ckpt_restore    = 1'b1;
    ckpt_restore_id = 2'd0;
    tick();
    idle();
    rd2(5'd1, 5'd0);
    chk("rest_busy", {31'd0, src_busy[0]}, 32'h0);
    chk("rest_val", src_val[31:0], 32'hAB);
    chk("rest_id", {30'd0, ckpt_id}, 32'h0);
    chk("rest_full", {31'd0, ckpt_full}, 32'h0);

    // fill, overflow, release+save
    ckpt_save = 1'b1;
    tick();
    chk("fill1", {30'd0, ckpt_id}, 32'h1);
    tick();
    chk("fill2", {30'd0, ckpt_id}, 32'h2);
    tick();
    chk("fill3", {30'd0, ckpt_id}, 32'h3);
    chk("fill3_full", {31'd0, ckpt_full}, 32'h0);
    tick();
    chk("fill4", {30'd0, ckpt_id}, 32'h0);
    chk("fill4_full", {31'd0, ckpt_full}, 32'h1);
    tick();
    chk("drop_id", {30'd0, ckpt_id}, 32'h0);
    chk("drop_full", {31'd0, ckpt_full}, 32'h1);
    ckpt_release = 1'b1;
    tick();
    idle();
    chk("relsave_id", {30'd0, ckpt_id}, 32'h1);
    chk("relsave_full", {31'd0, ckpt_full}, 32'h1);

    // flush
    ren(5'd4, 4'd9);
    tick();
    idle();
    flush_in = 1'b1;
    ren(5'd2, 4'd8);
    cm(5'd3, 4'd0, 32'h42);
    tick();
    idle();
    rd2(5'd3, 5'd2);
    chk("flush_cm", src_val[31:0], 32'h42);
    chk("flush_ren", {31'd0, src_busy[1]}, 32'h0);
    rd2(5'd4, 5'd0);
    chk("flush_clr", {31'd0, src_busy[0]}, 32'h0);
    chk("flush_id", {30'd0, ckpt_id}, 32'h0);
    chk("flush_full", {31'd0, ckpt_full}, 32'h0);
    ren(5'd0, 4'd5);
    tick();
    idle();
    rd2(5'd0, 5'd0);
    chk("x0_busy", {31'd0, src_busy[0]}, 32'h0);
    chk("x0_val", src_val[31:0], 32'h0);
    ckpt_release = 1'b1;
    tick();
    idle();
    chk("rel_empty_id", {30'd0, ckpt_id}, 32'h0);
    chk("rel_empty_full", {31'd0, ckpt_full}, 32'h0);
    ckpt_save = 1'b1;
    tick();
    idle();
    chk("save_after_rel", {30'd0, ckpt_id}, 32'h1);

    // freeze
    rdy_in = 1'b0;
    ren(5'd8, 4'd4);
    cm(5'd9, 4'd0, 32'h99);
    ckpt_save = 1'b1;
    tick();
    idle();
    rdy_in = 1'b1;
    rd2(5'd8, 5'd9);
    chk("frz_busy", {31'd0, src_busy[0]}, 32'h0);
    chk("frz_reg", src_val[63:32], 32'h0);
    chk("frz_id", {30'd0, ckpt_id}, 32'h1);

    // asynchronous reset mid-run
    ren(5'd6, 4'd5);
    ckpt_save = 1'b1;
    tick();
    idle();
    ren(5'd7, 4'd6);
    tick();
    idle();
    rd2(5'd6, 5'd7);
    chk("pre_rst_busy", {30'd0, src_busy}, 32'h3);
    chk("pre_rst_id", {30'd0, ckpt_id}, 32'h2);
    #1;
    rst_in = 1'b1;
    #1;
    chk("async_busy", {30'd0, src_busy}, 32'h0);
    chk("async_id", {30'd0, ckpt_id}, 32'h0);
    tick();
    rst_in = 1'b0;
    tick();
    rd2(5'd6, 5'd3);
    chk("post_rst_busy", {30'd0, src_busy}, 32'h0);
    chk("post_rst_reg", src_val[63:32], 32'h0);
    chk("post_rst_id", {30'd0, ckpt_id}, 32'h0);
    chk("post_rst_full", {31'd0, ckpt_full}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
